mpydiv9900: RTL

//  Multi-cycle sequencer for the TMS9900 MPY and DIV instructions. It sits between the
//  CPU execute FSM and the alu9900 datapath and issues one ALU operation per clock.

---
 rtl/mpydiv9900_pkg.sv | 22 ++
 rtl/alu9900.sv | 37 +++
 rtl/alu9900_defs.vh | 5 +
 rtl/mpydiv9900.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mpydiv9900_pkg.sv
// Shared types and helpers for the TMS9900 MPY/DIV sequencer.
package mpydiv9900_pkg;

  // Operation selected by op_div at start.
  typedef enum logic {
    OP_MPY = 1'b0,
    OP_DIV = 1'b1
  } op_t;

  // Value of the step counter on the sixteenth (final) shift step.
  localparam logic [3:0] STEP_LAST = 4'd15;

  // True when none of the multiplier bits still waiting to be processed are set,
  // judged in the cycle that processes bit 'count' (before the register shifts).
  // The unprocessed bits after this step sit in mul[15-count:1].
  function automatic logic mul_rest_zero(input logic [15:0] mul, input logic [3:0] count);
    logic [15:0] rest;
    rest = (mul >> 1) << ({1'b0, count} + 5'd1);
    return rest == 16'h0000;
  endfunction

endpackage

// File: rtl/alu9900.sv
// Slice of the TMS9900 ALU covering the operations used by the MPY/DIV sequencer.
// arg1 is 17 bits wide so the divider can subtract from a 17-bit partial remainder.
module alu9900 (
  input  logic [16:0] arg1,
  input  logic [15:0] arg2,
  input  logic [3:0]  ope,
  output logic [15:0] alu_result,
  output logic        alu_flag_carry
);

  `include "alu9900_defs.vh"

  // Combinational operation decode; carry on sub means no borrow.
  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves it unassigned (no latch).
    alu_result     = arg1[15:0];
    alu_flag_carry = 1'b0;
    case (ope)
      ALU_LOAD1: begin
        alu_result     = arg1[15:0];
        alu_flag_carry = 1'b0;
      end
      ALU_ADD: begin
        {alu_flag_carry, alu_result} = {1'b0, arg1[15:0]} + {1'b0, arg2};
      end
      ALU_SUB: begin
        alu_flag_carry = (arg1 >= {1'b0, arg2});
        alu_result     = arg1[15:0] - arg2;
      end
      default: begin
        alu_result     = arg1[15:0];
        alu_flag_carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu9900_defs.vh
// ALU opcode encodings shared by alu9900 and every block that drives its ope input.
// Included inside module bodies, so it carries no include guard.
localparam logic [3:0] ALU_LOAD1 = 4'h0;
localparam logic [3:0] ALU_ADD   = 4'h2;
localparam logic [3:0] ALU_SUB   = 4'h3;

// File: rtl/mpydiv9900.sv
// Multi-cycle sequencer for the TMS9900 MPY and DIV instructions. Issues one
// alu9900 operation per clock: unsigned shift-add multiply (16x16->32) and
// restoring divide (32/16 -> 16 quotient, 16 remainder).
// Optional feature: define MPYDIV_EARLY_EXIT_EN to let MPY finish as soon as the
// remaining multiplier bits are all zero (product aligned in one cycle).
module mpydiv9900
  import mpydiv9900_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_div,
  input  logic [15:0] src,
  input  logic [15:0] dst_hi,
  input  logic [15:0] dst_lo,
  output logic        busy,
  output logic        done,
  output logic [15:0] result_hi,
  output logic [15:0] result_lo,
  output logic        overflow,
  output logic [16:0] alu_arg1,
  output logic [15:0] alu_arg2,
  output logic [3:0]  alu_ope,
  input  logic [15:0] alu_result,
  input  logic        alu_carry
);

  `include "alu9900_defs.vh"

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_STEP,
    S_DONE
  } state_t;

  state_t      state;
  op_t         op_q;
  logic [15:0] opnd_q;   // DIV: divisor; MPY: multiplicand added on set multiplier bits
  logic [15:0] w_hi;     // DIV: partial remainder; MPY: accumulator
  logic [15:0] w_lo;     // DIV: dividend low / quotient; MPY: multiplier / product low
  logic        ovf_q;
  logic [3:0]  count;

  logic        mpy_carry;
  logic [31:0] mpy_pair;
  logic [31:0] mpy_next;
  logic        mpy_exit;

  // Drive the ALU from the current state; idle value is load1 with zero operands.
  always_comb begin
    alu_arg1 = 17'h0;
    alu_arg2 = 16'h0;
    alu_ope  = ALU_LOAD1;
    case (state)
      S_CHECK: begin
        alu_arg1 = {1'b0, w_hi};
        alu_arg2 = opnd_q;
        alu_ope  = ALU_SUB;
      end
      S_STEP: begin
        if (op_q == OP_DIV) begin
          alu_arg1 = {w_hi, w_lo[15]};
          alu_arg2 = opnd_q;
          alu_ope  = ALU_SUB;
        end else begin
          alu_arg1 = {1'b0, w_hi};
          if (w_lo[0]) begin
            alu_arg2 = opnd_q;
            alu_ope  = ALU_ADD;
          end
        end
      end
      default: begin
        alu_arg1 = 17'h0;
        alu_arg2 = 16'h0;
        alu_ope  = ALU_LOAD1;
      end
    endcase
  end

  // Carry only feeds the accumulator on an add; load1 must shift in a zero.
  assign mpy_carry = (alu_ope == ALU_ADD) && alu_carry;
  assign mpy_pair  = {mpy_carry, alu_result, w_lo[15:1]};

`ifdef MPYDIV_EARLY_EXIT_EN
  // Skip the all-zero tail: do the remaining right shifts in one go and finish.
  assign mpy_exit = mul_rest_zero(w_lo, count);
  assign mpy_next = mpy_pair >> (STEP_LAST - count);
`else
  assign mpy_exit = (count == STEP_LAST);
  assign mpy_next = mpy_pair;
`endif

  // Sequencer FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= OP_MPY;
      opnd_q    <= 16'h0;
      w_hi      <= 16'h0;
      w_lo      <= 16'h0;
      ovf_q     <= 1'b0;
      count     <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      result_hi <= 16'h0;
      result_lo <= 16'h0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            op_q   <= op_t'(op_div);
            opnd_q <= op_div ? src : dst_hi;
            w_hi   <= op_div ? dst_hi : 16'h0;
            w_lo   <= op_div ? dst_lo : src;
            ovf_q  <= 1'b0;
            count  <= 4'd0;
            busy   <= 1'b1;
            state  <= op_div ? S_CHECK : S_STEP;
          end
        end
        S_CHECK: begin
          // No borrow means the quotient cannot fit in 16 bits (also catches src=0).
          if (alu_carry) begin
            ovf_q <= 1'b1;
            state <= S_DONE;
          end else begin
            count <= 4'd0;
            state <= S_STEP;
          end
        end
        S_STEP: begin
          count <= count + 4'd1;
          if (op_q == OP_DIV) begin
            if (alu_carry) begin
              w_hi <= alu_result;
              w_lo <= {w_lo[14:0], 1'b1};
            end else begin
              w_hi <= {w_hi[14:0], w_lo[15]};
              w_lo <= {w_lo[14:0], 1'b0};
            end
            if (count == STEP_LAST) state <= S_DONE;
          end else begin
            {w_hi, w_lo} <= mpy_next;
            if (mpy_exit) state <= S_DONE;
          end
        end
        S_DONE: begin
          done     <= 1'b1;
          busy     <= 1'b1;
          overflow <= ovf_q;
          if ((op_q == OP_DIV) && !ovf_q) begin
            result_hi <= w_lo;
            result_lo <= w_hi;
          end else begin
            result_hi <= w_hi;
            result_lo <= w_lo;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
